// File: rtl/sinc_seq_pkg.sv
// Shared state encoding and signed range helpers for the sinc_seq sequence source.
`default_nettype none

package sinc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Widest DATAWIDTH the range helpers can describe.
  localparam int MAX_DW = 64;

  // Most-positive and most-negative signed values, zero-extended to MAX_DW bits.
  function automatic logic [MAX_DW-1:0] smax_fn(input int dw);
    smax_fn = (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_DW-1:0] smin_fn(input int dw);
    smin_fn = 64'd1 << (dw - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sinc_seq_sinc.sv
// SINC: combinational signed incrementer (a -> a+1, modular DATAWIDTH), twin of the DEC primitive.
`default_nettype none

module sinc_seq_sinc
  import sinc_seq_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic signed [DATAWIDTH-1:0] a_i,
  output logic signed [DATAWIDTH-1:0] y_o
);

  assign y_o = a_i + {{(DATAWIDTH-1){1'b0}}, 1'b1};

endmodule

`default_nettype wire

// File: rtl/sinc_seq.sv
// sinc_seq: signed up-counting sequence source (first..last) with valid/ready output handshake.
`default_nettype none

module sinc_seq
  import sinc_seq_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] first,
  input  logic signed [DATAWIDTH-1:0] last,
  output logic signed [DATAWIDTH-1:0] d,
  output logic                        valid,
  input  logic                        ready,
  output logic                        busy,
  output logic                        done,
  output logic                        wrap
);

  localparam logic [MAX_DW-1:0] MAX_W = smax_fn(DATAWIDTH);
  localparam logic [MAX_DW-1:0] MIN_W = smin_fn(DATAWIDTH);
  localparam logic signed [DATAWIDTH-1:0] MAX_V = MAX_W[DATAWIDTH-1:0];
  localparam logic signed [DATAWIDTH-1:0] MIN_V = MIN_W[DATAWIDTH-1:0];

  state_e                      state_q;
  logic signed [DATAWIDTH-1:0] d_q;
  logic signed [DATAWIDTH-1:0] last_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        wrap_q;
  logic signed [DATAWIDTH-1:0] inc_d;

  sinc_seq_sinc #(
    .DATAWIDTH(DATAWIDTH)
  ) u_sinc (
    .a_i(d_q),
    .y_o(inc_d)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            last_q  <= last;
            d_q     <= first;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            wrap_q  <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // valid is always high in RUN, so ready alone marks an accepted element.
          if (ready) begin
            if (d_q == last_q) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (d_q == MAX_V) begin
              wrap_q <= 1'b1;
              if (SATURATE != 0) begin
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                d_q <= MIN_V;
              end
            end else begin
              d_q <= inc_d;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign d     = d_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_sinc_seq.sv
// Self-checking bench for sinc_seq: wrapping and saturating 8-bit instances against a list-based model.
`default_nettype none

module tb_sinc_seq;

  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start0 = 1'b0;
  logic                 start1 = 1'b0;
  logic signed [DW-1:0] first = '0;
  logic signed [DW-1:0] last = '0;
  logic                 ready = 1'b0;

  logic signed [DW-1:0] d0, d1;
  logic                 v0, v1, b0, b1, dn0, dn1, w0, w1;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  sinc_seq #(.DATAWIDTH(DW), .SATURATE(0)) u_wrap (
    .Clk(clk), .Rst(rst), .start(start0), .first(first), .last(last),
    .d(d0), .valid(v0), .ready(ready), .busy(b0), .done(dn0), .wrap(w0)
  );

  sinc_seq #(.DATAWIDTH(DW), .SATURATE(1)) u_sat (
    .Clk(clk), .Rst(rst), .start(start1), .first(first), .last(last),
    .d(d1), .valid(v1), .ready(ready), .busy(b1), .done(dn1), .wrap(w1)
  );

  logic signed [DW-1:0] sd;
  logic                 sv, sb, sdn, sw;
  assign sd  = sel ? d1  : d0;
  assign sv  = sel ? v1  : v0;
  assign sb  = sel ? b1  : b0;
  assign sdn = sel ? dn1 : dn0;
  assign sw  = sel ? w1  : w0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_start(input bit val);
    if (sel) start1 = val;
    else     start0 = val;
  endtask

  // Model: list the elements the sequence must emit, straight from first/last and the range rules.
  task automatic run_seq(input bit s, input int f, input int l, input int rmode, input bit poke);
    int  exp[$];
    int  v;
    bit  wr_final;
    bit  wsf;
    int  idx;
    int  cyc;
    bit  hold;
    logic signed [DW-1:0] prev_d;
    bit  rdy;
    logic [DW-1:0] tmp;

    exp.delete();
    wr_final = 1'b0;
    v = f;
    forever begin
      exp.push_back(v);
      if (v == l) break;
      if (v == 127) begin
        wr_final = 1'b1;
        if (s) break;
        v = -128;
      end else begin
        v = v + 1;
      end
    end

    sel = s;
    @(negedge clk);
    tmp = f[DW-1:0]; first = tmp;
    tmp = l[DW-1:0]; last  = tmp;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    first = DW'($urandom);
    last  = DW'($urandom);

    idx = 0; wsf = 1'b0; cyc = 0; hold = 1'b0; prev_d = '0;
    while (idx < exp.size() && cyc < 2000) begin
      chk("run_valid", sv, 1);
      chk("run_busy", sb, 1);
      chk("run_done", sdn, 0);
      chk("run_wrap", sw, wsf);
      if (hold) chk("hold_d", sd, prev_d);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready = rdy;
      if (poke) set_start(1'($urandom_range(0, 1)));
      if (rdy) begin
        chk("elem_d", sd, exp[idx]);
        if (exp[idx] == 127 && exp[idx] != l) wsf = 1'b1;
        idx++;
        hold = 1'b0;
      end else begin
        hold = 1'b1;
        prev_d = sd;
      end
      cyc++;
      @(negedge clk);
    end
    if (idx < exp.size()) chk("seq_timeout", idx, exp.size());

    chk("fin_done", sdn, 1);
    chk("fin_valid", sv, 0);
    chk("fin_busy", sb, 0);
    ready = 1'($urandom_range(0, 1));
    set_start(poke);
    @(negedge clk);
    set_start(1'b0);
    chk("idle_done", sdn, 0);
    chk("idle_valid", sv, 0);
    chk("idle_busy", sb, 0);
    chk("idle_wrap", sw, wr_final);
    chk("idle_d", sd, exp[exp.size()-1]);
    @(negedge clk);
    chk("idle2_valid", sv, 0);
    chk("idle2_done", sdn, 0);
  endtask

  initial begin
    int f, l;
    bit s;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_d0", d0, 0);   chk("rst_valid0", v0, 0); chk("rst_busy0", b0, 0);
    chk("rst_done0", dn0, 0); chk("rst_wrap0", w0, 0);
    chk("rst_d1", d1, 0);   chk("rst_valid1", v1, 0); chk("rst_busy1", b1, 0);
    chk("rst_done1", dn1, 0); chk("rst_wrap1", w1, 0);

    run_seq(1'b0, -3, 2, 0, 1'b0);
    run_seq(1'b0, -3, 2, 1, 1'b0);
    run_seq(1'b0, 126, -127, 2, 1'b0);
    run_seq(1'b1, 126, -127, 2, 1'b0);
    run_seq(1'b0, 5, 5, 0, 1'b1);
    run_seq(1'b1, 5, 5, 2, 1'b1);
    run_seq(1'b1, 120, 127, 0, 1'b0);
    run_seq(1'b1, 126, 100, 1, 1'b1);
    run_seq(1'b0, 127, 127, 0, 1'b0);

    // Reset in the middle of a wrapping sequence: outputs clear, no done pulse.
    sel = 1'b0;
    @(negedge clk);
    first = 8'sd125; last = -8'sd120; start0 = 1'b1; ready = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_wrap", w0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_d", d0, 0);     chk("mid_rst_valid", v0, 0);
    chk("mid_rst_busy", b0, 0);  chk("mid_rst_done", dn0, 0);
    chk("mid_rst_wrap", w0, 0);
    @(negedge clk);
    chk("post_rst_done", dn0, 0); chk("post_rst_valid", v0, 0);

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      f = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 1) == 0) begin
        l = f + int'($urandom_range(0, 12));
        if (l > 127) l = l - 256;
      end else begin
        l = int'($urandom_range(0, 255)) - 128;
      end
      run_seq(s, f, l, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
